// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and access sequencer for a
// single-port, big-endian, byte-addressed data RAM. Each accepted request
// takes three cycles: grant (IDLE), RAM access (ACCESS), response (RESP).
module mem_arbiter #(
    parameter int unsigned MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_we,
    input  logic [1:0]  p0_req_size,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_rsp_valid,
    output logic [31:0] p0_rsp_rdata,
    output logic        p0_rsp_err,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_we,
    input  logic [1:0]  p1_req_size,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_rsp_valid,
    output logic [31:0] p1_rsp_rdata,
    output logic        p1_rsp_err,

    output logic [2:0]  ram_write_enable,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    // Round-robin pointer: port that wins when both request.
    logic        prio;

    // Latched request.
    logic        lat_port;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    // Result captured in ACCESS, presented in RESP.
    logic [31:0] cap_data;
    logic        cap_err;

    logic        grant;
    logic        grant_port;

    logic [2:0]  nbytes;
    logic [32:0] last_byte;
    logic        req_err;
    logic [2:0]  we_code;
    logic [31:0] load_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, next state, handshake, RAM strobe and response outputs.
    always_comb begin
        state_next       = state;
        grant            = 1'b0;
        grant_port       = 1'b0;
        p0_req_ready     = 1'b0;
        p1_req_ready     = 1'b0;
        ram_write_enable = '0;
        p0_rsp_valid     = 1'b0;
        p0_rsp_rdata     = '0;
        p0_rsp_err       = 1'b0;
        p1_rsp_valid     = 1'b0;
        p1_rsp_rdata     = '0;
        p1_rsp_err       = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req_valid || p1_req_valid) begin
                    grant        = 1'b1;
                    grant_port   = (p0_req_valid && p1_req_valid) ? prio : p1_req_valid;
                    p0_req_ready = ~grant_port;
                    p1_req_ready = grant_port;
                    state_next   = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_we && !req_err) begin
                    ram_write_enable = we_code;
                end
                state_next = RESP;
            end
            RESP: begin
                if (lat_port) begin
                    p1_rsp_valid = 1'b1;
                    p1_rsp_rdata = cap_data;
                    p1_rsp_err   = cap_err;
                end else begin
                    p0_rsp_valid = 1'b1;
                    p0_rsp_rdata = cap_data;
                    p0_rsp_err   = cap_err;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the granted request and rotate the priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio      <= 1'b0;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant) begin
            prio     <= ~grant_port;
            lat_port <= grant_port;
            if (grant_port) begin
                lat_we    <= p1_req_we;
                lat_size  <= p1_req_size;
                lat_addr  <= p1_req_addr;
                lat_wdata <= p1_req_wdata;
            end else begin
                lat_we    <= p0_req_we;
                lat_size  <= p0_req_size;
                lat_addr  <= p0_req_addr;
                lat_wdata <= p0_req_wdata;
            end
        end
    end

    // Alignment/range checks, write-enable encoding and load extraction.
    always_comb begin
        case (lat_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        // 33-bit sum so addresses near 2^32 cannot wrap into range.
        last_byte = {1'b0, lat_addr} + {30'b0, nbytes} - 33'd1;
        req_err   = (lat_size == 2'd3)
                 || (lat_size == 2'd1 && lat_addr[0])
                 || (lat_size == 2'd2 && lat_addr[1:0] != 2'b00)
                 || (last_byte >= 33'(MEM_BYTES));
        case (lat_size)
            2'd0:    we_code = 3'b100;
            2'd1:    we_code = 3'b010;
            2'd2:    we_code = 3'b001;
            default: we_code = 3'b000;
        endcase
        case (lat_size)
            2'd0:    load_data = {24'b0, ram_data_out[31:24]};
            2'd1:    load_data = {16'b0, ram_data_out[31:16]};
            default: load_data = ram_data_out;
        endcase
    end

    // Register the response payload at the end of ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_data <= '0;
            cap_err  <= 1'b0;
        end else if (state == ACCESS) begin
            cap_err  <= req_err;
            cap_data <= (req_err || lat_we) ? 32'd0 : load_data;
        end
    end

    assign ram_addr    = lat_addr;
    assign ram_data_in = lat_wdata;

endmodule
